// File: rtl/ethernet_tx_serializer.sv
// Serial Ethernet-style frame transmitter: preamble/SFD, MACs, length, payload, CRC-32.
// One bit per clock, MSB first, fed by a byte-wide valid/ready payload stream.
module ethernet_tx_serializer #(
  parameter int unsigned MAX_LEN = 1500,
  parameter logic [47:0] DST_MAC = 48'h0000_0000_0000,
  parameter logic [47:0] SRC_MAC = 48'h0000_0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [15:0] Length,
  input  logic [7:0]  Data_in,
  input  logic        Data_valid,
  output logic        Data_ready,
  output logic        Tx_bit,
  output logic        Tx_en,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);
  localparam logic [63:0] PREAMBLE = 64'hAAAA_AAAA_AAAA_AAAB;
  localparam logic [95:0] ADDR     = {DST_MAC, SRC_MAC};
  localparam logic [31:0] POLY     = 32'h04C11DB7;

  typedef enum logic [2:0] {IDLE, PRE, ADR, LEN, PAY, CRC} state_t;

  state_t      state;
  logic [6:0]  cnt;
  logic [15:0] len_q;
  logic [15:0] acc_cnt;
  logic [15:0] sent_cnt;
  logic [7:0]  hold;
  logic        hold_full;
  logic [7:0]  shreg;
  logic [31:0] crc;
  logic        take;
  logic        need_byte;
  logic        load;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'h0);
  endfunction

  // Derived purely from registers, so no input-to-output combinational path.
  assign Data_ready = Busy & ~hold_full & (acc_cnt < len_q);
  assign take       = Data_valid & Data_ready;
  assign need_byte  = ((state == LEN) && (cnt == 7'd15) && (len_q != 16'd0)) ||
                      ((state == PAY) && (cnt[2:0] == 3'd7) && (sent_cnt != len_q));
  assign load       = need_byte & hold_full;

  // Holding buffer: filled by the handshake, emptied when PAY loads the shifter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
      acc_cnt   <= 16'd0;
    end else if (state == IDLE) begin
      hold_full <= 1'b0;
      acc_cnt   <= 16'd0;
    end else if (take) begin
      hold      <= Data_in;
      hold_full <= 1'b1;
      acc_cnt   <= acc_cnt + 16'd1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // state/cnt describe the bit currently on the line; each edge selects the next one.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= 7'd0;
      len_q    <= 16'd0;
      sent_cnt <= 16'd0;
      shreg    <= 8'd0;
      crc      <= 32'd0;
      Tx_bit   <= 1'b0;
      Tx_en    <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      cnt   <= cnt + 7'd1;
      case (state)
        IDLE: begin
          cnt <= 7'd0;
          if (Start) begin
            if (32'(Length) > MAX_LEN) begin
              Error <= 1'b1;
            end else begin
              state    <= PRE;
              len_q    <= Length;
              sent_cnt <= 16'd0;
              crc      <= 32'd0;
              Tx_bit   <= PREAMBLE[63];
              Tx_en    <= 1'b1;
              Busy     <= 1'b1;
            end
          end
        end
        PRE: begin
          if (cnt == 7'd63) begin
            state  <= ADR;
            cnt    <= 7'd0;
            Tx_bit <= ADDR[95];
          end else begin
            Tx_bit <= PREAMBLE[6'd62 - cnt[5:0]];
          end
        end
        ADR: begin
          if (cnt == 7'd95) begin
            state  <= LEN;
            cnt    <= 7'd0;
            Tx_bit <= len_q[15];
          end else begin
            Tx_bit <= ADDR[7'd94 - cnt];
          end
        end
        LEN, PAY: begin
          if (need_byte) begin
            if (hold_full) begin
              state    <= PAY;
              cnt      <= 7'd0;
              Tx_bit   <= hold[7];
              shreg    <= {hold[6:0], 1'b0};
              crc      <= crc_step(crc, hold[7]);
              sent_cnt <= sent_cnt + 16'd1;
            end else begin
              // Underrun: abandon the frame without a Done.
              state  <= IDLE;
              Tx_bit <= 1'b0;
              Tx_en  <= 1'b0;
              Busy   <= 1'b0;
              Error  <= 1'b1;
            end
          end else if ((state == LEN && cnt == 7'd15) ||
                       (state == PAY && cnt[2:0] == 3'd7)) begin
            state  <= CRC;
            cnt    <= 7'd0;
            Tx_bit <= crc[31];
            crc    <= {crc[30:0], 1'b0};
          end else if (state == LEN) begin
            Tx_bit <= len_q[4'd14 - cnt[3:0]];
          end else begin
            Tx_bit <= shreg[7];
            shreg  <= {shreg[6:0], 1'b0};
            crc    <= crc_step(crc, shreg[7]);
          end
        end
        CRC: begin
          if (cnt == 7'd31) begin
            state  <= IDLE;
            cnt    <= 7'd0;
            Tx_bit <= 1'b0;
            Tx_en  <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b1;
          end else begin
            Tx_bit <= crc[31];
            crc    <= {crc[30:0], 1'b0};
          end
        end
        default: begin
          state <= IDLE;
          Tx_en <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ethernet_tx_serializer.sv
// Scoreboard bench: stimulus pushes the expected bit stream and end event,
// a monitor pops and compares every transmitted bit and every Done/Error pulse.
module tb_ethernet_tx_serializer;
  localparam logic [47:0] DST  = 48'h0123_4567_89AB;
  localparam logic [47:0] SRC  = 48'hDEAD_BEEF_CAFE;
  localparam int          MAXL = 1500;
  localparam logic [32:0] GPOLY = 33'h1_04C1_1DB7;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Length = 16'd0;
  logic [7:0]  Data_in = 8'd0;
  logic        Data_valid = 1'b0;
  logic        Data_ready, Tx_bit, Tx_en, Busy, Done, Error;

  ethernet_tx_serializer #(.MAX_LEN(MAXL), .DST_MAC(DST), .SRC_MAC(SRC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Length(Length), .Data_in(Data_in),
    .Data_valid(Data_valid), .Data_ready(Data_ready), .Tx_bit(Tx_bit), .Tx_en(Tx_en),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct { bit is_err; int nbits; } end_t;

  bit           exp_bits[$];
  end_t         exp_end[$];
  byte unsigned pay[$];
  int checks = 0;
  int failures = 0;
  int cur_bits = 0;
  int bit_err = 0;
  int line_err = 0;

  // Reference CRC: remainder of (payload * x^32) divided by G, by long division.
  function automatic logic [31:0] model_crc(input int n);
    bit m[$];
    logic [31:0] r;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) m.push_back(pay[i][b]);
    for (int i = 0; i < 32; i++) m.push_back(1'b0);
    for (int i = 0; i < 8 * n; i++)
      if (m[i]) for (int j = 0; j < 33; j++) m[i+j] = m[i+j] ^ GPOLY[32-j];
    for (int i = 0; i < 32; i++) r[31-i] = m[8*n+i];
    return r;
  endfunction

  function automatic void push_field(input logic [95:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) exp_bits.push_back(v[i]);
  endfunction

  function automatic void push_expected(input int len, input int nsup);
    end_t e;
    push_field(96'(64'hAAAA_AAAA_AAAA_AAAB), 64);
    push_field({DST, SRC}, 96);
    push_field(96'(len), 16);
    if (nsup >= len) begin
      for (int i = 0; i < len; i++) push_field(96'(pay[i]), 8);
      push_field(96'(model_crc(len)), 32);
      e.is_err = 1'b0;
      e.nbits  = 208 + 8 * len;
    end else begin
      for (int i = 0; i < nsup; i++) push_field(96'(pay[i]), 8);
      e.is_err = 1'b1;
      e.nbits  = 176 + 8 * nsup;
    end
    exp_end.push_back(e);
  endfunction

  // Monitor: consumes expected bits while Tx_en is high, settles each frame on Done/Error.
  always @(negedge Clk) begin : monitor
    bit   eb;
    end_t e;
    if (!Rst_n) begin
      cur_bits = 0;
      bit_err  = 0;
    end else begin
      if (Tx_en) begin
        cur_bits++;
        if (exp_bits.size() == 0) bit_err++;
        else begin
          eb = exp_bits.pop_front();
          if (Tx_bit !== eb) bit_err++;
        end
      end else if (Tx_bit !== 1'b0) line_err++;
      if (Busy !== Tx_en) line_err++;
      if (Done || Error) begin
        checks++;
        if (exp_end.size() == 0) begin
          failures++;
          $display("FAIL unexpected_end done=%0b error=%0b bits=%0d required=no_event", Done, Error, cur_bits);
        end else begin
          e = exp_end.pop_front();
          if ({Done, Error} !== {~e.is_err, e.is_err}) begin
            failures++;
            $display("FAIL end_kind done/error=%0b%0b required=%0b%0b", Done, Error, ~e.is_err, e.is_err);
          end
          checks++;
          if (cur_bits != e.nbits) begin
            failures++;
            $display("FAIL frame_len bits=%0d required=%0d", cur_bits, e.nbits);
          end
          checks++;
          if (bit_err != 0) begin
            failures++;
            $display("FAIL frame_bits wrong_bits=%0d required=0", bit_err);
          end
          checks++;
          if (Tx_en !== 1'b0) begin
            failures++;
            $display("FAIL en_at_end tx_en=%0b required=0", Tx_en);
          end
        end
        cur_bits = 0;
        bit_err  = 0;
      end
    end
  end

  task automatic reset_phase(input int cycles, input bit immediate);
    Rst_n = 1'b0;
    #1;
    exp_bits.delete();
    exp_end.delete();
    if (immediate) begin
      checks++;
      if ({Data_ready, Tx_bit, Tx_en, Busy, Done, Error} !== 6'b0) begin
        failures++;
        $display("FAIL reset_async outputs=%b required=000000", {Data_ready, Tx_bit, Tx_en, Busy, Done, Error});
      end
    end
    for (int i = 0; i < cycles; i++) begin
      Start      = 1'b1;
      Length     = 16'($urandom_range(0, 4));
      Data_valid = 1'($urandom);
      Data_in    = 8'($urandom);
      @(negedge Clk);
      checks++;
      if ({Data_ready, Tx_bit, Tx_en, Busy, Done, Error} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs outputs=%b required=000000", {Data_ready, Tx_bit, Tx_en, Busy, Done, Error});
      end
    end
    Start      = 1'b0;
    Data_valid = 1'b0;
    Rst_n      = 1'b1;
  endtask

  // Caller is at a negedge; Start is driven immediately (this may be a Done cycle).
  task automatic run_frame(input int len, input int nsup, input int abort_at);
    int idx, gap, exp_acc;
    bit pv, pr, seen_ready, ended;
    push_expected(len, nsup);
    Start  = 1'b1;
    Length = 16'(len);
    @(negedge Clk);
    Start = 1'b0;
    idx = 0; gap = 0; pv = 0; pr = 0; seen_ready = 0; ended = 0;
    for (int c = 0; c < 14000; c++) begin
      if (pv && pr) idx++;
      if (Data_ready) seen_ready = 1'b1;
      if (Done || Error) begin
        ended = 1'b1;
        break;
      end
      if (c == abort_at) begin
        Data_valid = 1'b0;
        reset_phase(2, 1'b1);
        return;
      end
      Start  = ($urandom_range(0, 15) == 0);
      Length = 16'($urandom_range(0, 2000));
      if (idx < nsup && (gap >= 3 || $urandom_range(0, 1) == 1)) begin
        Data_valid = 1'b1;
        Data_in    = pay[idx];
        gap        = 0;
      end else begin
        Data_valid = 1'b0;
        Data_in    = 8'($urandom);
        gap++;
      end
      pv = Data_valid;
      pr = Data_ready;
      @(negedge Clk);
    end
    Start      = 1'b0;
    Data_valid = 1'b0;
    checks++;
    if (!ended) begin
      failures++;
      $display("FAIL frame_timeout ended=0 required=1 len=%0d", len);
    end
    exp_acc = (nsup < len) ? nsup : len;
    checks++;
    if (idx != exp_acc) begin
      failures++;
      $display("FAIL accepted_bytes got=%0d required=%0d", idx, exp_acc);
    end
    if (len == 0) begin
      checks++;
      if (seen_ready) begin
        failures++;
        $display("FAIL ready_on_zero_len data_ready_seen=1 required=0");
      end
    end
  endtask

  task automatic reject(input int len);
    end_t e;
    e.is_err = 1'b1;
    e.nbits  = 0;
    exp_end.push_back(e);
    Start  = 1'b1;
    Length = 16'(len);
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      Data_in = 8'($urandom);
      @(negedge Clk);
    end
  endtask

  task automatic fill_random(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    reset_phase(4, 1'b0);
    idle(2);

    pay.delete(); pay.push_back(8'h01);
    run_frame(1, 1, -1);
    idle(3);

    pay.delete(); repeat (3) pay.push_back(8'h00);
    run_frame(3, 3, -1);
    idle(2);

    pay.delete();
    run_frame(0, 0, -1);
    idle(2);

    fill_random(2);
    run_frame(2, 1, -1);
    idle(2);

    fill_random(2);
    run_frame(2, 0, -1);
    idle(2);

    reject(1501);
    reject(16'hFFFF);

    for (int k = 0; k < 8; k++) begin
      fill_random($urandom_range(0, 24));
      run_frame(pay.size(), pay.size(), -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end

    fill_random(5);
    run_frame(5, 3, -1);
    idle(2);

    fill_random(MAXL);
    run_frame(MAXL, MAXL, -1);

    fill_random(4);
    run_frame(4, 4, 180);
    idle(2);

    pay.delete(); pay.push_back(8'($urandom));
    run_frame(1, 1, -1);
    idle(4);

    checks++;
    if (exp_end.size() != 0 || exp_bits.size() != 0) begin
      failures++;
      $display("FAIL leftover_expect events=%0d bits=%0d required=0", exp_end.size(), exp_bits.size());
    end
    checks++;
    if (line_err != 0) begin
      failures++;
      $display("FAIL line_rules violations=%0d required=0", line_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
